// File: rtl/any1_mul_unit.sv
// ANY1 multiply functional unit: queues dispatched records and executes them
// through a three-stage 64x64 multiply, returning the result and cause to the ROB.
module any1_mul_unit #(
    parameter int unsigned QDEP = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_i,
    input  logic [5:0]  rid_i,
    input  logic [31:0] ir_i,
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    input  logic [63:0] imm_i,
    output logic        full_o,
    output logic        ovf_o,
    input  logic        flush_i,
    output logic        cmt_o,
    output logic [5:0]  rid_o,
    output logic [63:0] res_o,
    output logic [7:0]  cause_o,
    input  logic        ack_i
);

    localparam int unsigned PW = (QDEP > 1) ? $clog2(QDEP) : 1;
    localparam int unsigned CW = $clog2(QDEP + 1);

    localparam logic [7:0] OP_R2     = 8'h02;
    localparam logic [7:0] OP_MULI   = 8'h06;
    localparam logic [7:0] OP_MULUI  = 8'h0E;
    localparam logic [7:0] OP_MULSUI = 8'h16;
    localparam logic [7:0] FLT_NONE  = 8'h00;
    localparam logic [7:0] FLT_UNIMP = 8'h37;

    typedef struct packed {
        logic [5:0]  rid;
        logic [63:0] a;
        logic [63:0] b;
        logic        ok;     // implemented operation
        logic        hi;     // return upper half of the product
        logic        a_sgn;
        logic        b_sgn;
    } rec_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL1,
        S_MUL2,
        S_MUL3,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    rec_t            mem [QDEP];
    rec_t            rec_c;
    rec_t            head_c;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            push_c, pop_c;
    logic            unused_ir_c;

    logic [63:0]     op_a_q, op_b_q;
    logic            op_ok_q, op_hi_q, op_as_q, op_bs_q;
    logic [5:0]      op_rid_q;
    logic [63:0]     mag_a_c, mag_b_c;
    logic [63:0]     pp_ll_q, pp_lh_q, pp_hl_q, pp_hh_q;
    logic            neg_q;
    logic [127:0]    sum_c;
    logic [127:0]    prod_q;

    // Register fields are not needed by this unit
    assign unused_ir_c = ^ir_i[25:8];

    // Decode at push time so the queue only carries what execution needs
    always_comb begin
        rec_c     = '0;
        rec_c.rid = rid_i;
        rec_c.a   = a_i;
        rec_c.b   = b_i;
        unique case (ir_i[7:0])
            OP_R2: begin
                unique case (ir_i[31:26])
                    6'h06: begin rec_c.ok = 1'b1; rec_c.a_sgn = 1'b1; rec_c.b_sgn = 1'b1; end
                    6'h0E: begin rec_c.ok = 1'b1; end
                    6'h16: begin rec_c.ok = 1'b1; rec_c.a_sgn = 1'b1; end
                    6'h0F: begin rec_c.ok = 1'b1; rec_c.hi = 1'b1; rec_c.a_sgn = 1'b1; rec_c.b_sgn = 1'b1; end
                    6'h1E: begin rec_c.ok = 1'b1; rec_c.hi = 1'b1; end
                    6'h1D: begin rec_c.ok = 1'b1; rec_c.hi = 1'b1; rec_c.a_sgn = 1'b1; end
                    default: rec_c.ok = 1'b0;
                endcase
            end
            OP_MULI:   begin rec_c.ok = 1'b1; rec_c.b = imm_i; rec_c.a_sgn = 1'b1; rec_c.b_sgn = 1'b1; end
            OP_MULUI:  begin rec_c.ok = 1'b1; rec_c.b = imm_i; end
            OP_MULSUI: begin rec_c.ok = 1'b1; rec_c.b = imm_i; rec_c.a_sgn = 1'b1; end
            default:   rec_c.ok = 1'b0;
        endcase
    end

    assign push_c = wr_i && !flush_i && (count_q != CW'(QDEP));
    assign head_c = mem[rd_ptr_q];

    always_comb begin
        count_d = count_q + CW'(push_c) - CW'(pop_c);
    end

    // Next-state and pop decision; flush overrides everything but reset
    always_comb begin
        state_d = state_q;
        pop_c   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop_c   = 1'b1;
                    state_d = S_MUL1;
                end
            end
            S_MUL1: state_d = S_MUL2;
            S_MUL2: state_d = S_MUL3;
            S_MUL3: state_d = S_DONE;
            S_DONE: begin
                if (ack_i) begin
                    if (count_q != '0) begin
                        pop_c   = 1'b1;
                        state_d = S_MUL1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush_i) begin
            state_d = S_IDLE;
            pop_c   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Queue pointers, occupancy and overflow pulse
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_o   <= 1'b0;
            ovf_o    <= 1'b0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            full_o  <= (count_d == CW'(QDEP));
            ovf_o   <= wr_i && (count_q == CW'(QDEP));
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_c) mem[wr_ptr_q] <= rec_c;
    end

    assign mag_a_c = (op_as_q && op_a_q[63]) ? (64'd0 - op_a_q) : op_a_q;
    assign mag_b_c = (op_bs_q && op_b_q[63]) ? (64'd0 - op_b_q) : op_b_q;
    assign sum_c   = {pp_hh_q, pp_ll_q}
                   + {32'd0, pp_lh_q, 32'd0}
                   + {32'd0, pp_hl_q, 32'd0};

    // Multiply pipeline: latch, partial products, sum and sign fix-up
    always_ff @(posedge clk_i) begin
        if (pop_c) begin
            op_a_q   <= head_c.a;
            op_b_q   <= head_c.b;
            op_ok_q  <= head_c.ok;
            op_hi_q  <= head_c.hi;
            op_as_q  <= head_c.a_sgn;
            op_bs_q  <= head_c.b_sgn;
            op_rid_q <= head_c.rid;
        end
        if (state_q == S_MUL1) begin
            pp_ll_q <= 64'(mag_a_c[31:0])  * 64'(mag_b_c[31:0]);
            pp_lh_q <= 64'(mag_a_c[31:0])  * 64'(mag_b_c[63:32]);
            pp_hl_q <= 64'(mag_a_c[63:32]) * 64'(mag_b_c[31:0]);
            pp_hh_q <= 64'(mag_a_c[63:32]) * 64'(mag_b_c[63:32]);
            neg_q   <= (op_as_q && op_a_q[63]) ^ (op_bs_q && op_b_q[63]);
        end
        if (state_q == S_MUL2) begin
            prod_q <= neg_q ? (128'd0 - sum_c) : sum_c;
        end
    end

    // Result held toward the ROB until acknowledged
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmt_o   <= 1'b0;
            rid_o   <= '0;
            res_o   <= '0;
            cause_o <= '0;
        end else if (flush_i) begin
            cmt_o <= 1'b0;
        end else if (state_q == S_MUL3) begin
            cmt_o   <= 1'b1;
            rid_o   <= op_rid_q;
            res_o   <= !op_ok_q ? 64'd0 : (op_hi_q ? prod_q[127:64] : prod_q[63:0]);
            cause_o <= op_ok_q ? FLT_NONE : FLT_UNIMP;
        end else if (state_q == S_DONE && ack_i) begin
            cmt_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_any1_mul_unit.sv
// Scoreboard bench for any1_mul_unit: directed records, expected results queued
// at issue and matched by a monitor on each accepted result.
module tb_any1_mul_unit;

    logic        clk = 1'b0;
    logic        rst_i, wr_i, flush_i, ack_i;
    logic [5:0]  rid_i;
    logic [31:0] ir_i;
    logic [63:0] a_i, b_i, imm_i;
    logic        full_o, ovf_o, cmt_o;
    logic [5:0]  rid_o;
    logic [63:0] res_o;
    logic [7:0]  cause_o;

    typedef struct {
        logic [5:0]  rid;
        logic [63:0] res;
        logic [7:0]  cause;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    any1_mul_unit #(.QDEP(4)) dut (
        .clk_i(clk), .rst_i(rst_i), .wr_i(wr_i), .rid_i(rid_i), .ir_i(ir_i),
        .a_i(a_i), .b_i(b_i), .imm_i(imm_i), .full_o(full_o), .ovf_o(ovf_o),
        .flush_i(flush_i), .cmt_o(cmt_o), .rid_o(rid_o), .res_o(res_o),
        .cause_o(cause_o), .ack_i(ack_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_ir(input logic [7:0] op, input logic [5:0] fn);
        return {fn, 18'd0, op};
    endfunction

    // Monitor: every result handshake must match the oldest expectation
    always @(negedge clk) begin
        if (!rst_i && cmt_o && ack_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_cmt rid=%0d res=%h cause=%h", rid_o, res_o, cause_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (rid_o !== e.rid || res_o !== e.res || cause_o !== e.cause) begin
                    failures++;
                    $display("FAIL result got rid=%0d res=%h cause=%h exp rid=%0d res=%h cause=%h",
                             rid_o, res_o, cause_o, e.rid, e.res, e.cause);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic set_rec(input logic [5:0] rid, input logic [31:0] ir,
                           input logic [63:0] a, input logic [63:0] b, input logic [63:0] imm);
        wr_i = 1'b1; rid_i = rid; ir_i = ir; a_i = a; b_i = b; imm_i = imm;
    endtask

    task automatic expect_res(input logic [5:0] rid, input logic [63:0] res, input logic [7:0] cause);
        exp_t e;
        e.rid = rid; e.res = res; e.cause = cause;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || cmt_o) && n < 60) begin
            tick();
            n++;
        end
        chk({name, "_drain_timeout"}, 64'(n >= 60), 64'd0);
    endtask

    // Single record into an idle unit, checking the four-edge latency
    task automatic one_op(input string name, input logic [5:0] rid, input logic [31:0] ir,
                          input logic [63:0] a, input logic [63:0] b, input logic [63:0] imm,
                          input logic [63:0] res, input logic [7:0] cause);
        expect_res(rid, res, cause);
        set_rec(rid, ir, a, b, imm);
        tick();
        wr_i = 1'b0;
        tick(); tick(); tick();
        chk({name, "_cmt_early"}, 64'(cmt_o), 64'd0);
        tick();
        chk({name, "_cmt_lat4"}, 64'(cmt_o), 64'd1);
        drain(name);
    endtask

    initial begin
        int seen;
        rst_i = 1'b1; wr_i = 1'b0; flush_i = 1'b0; ack_i = 1'b1;
        rid_i = '0; ir_i = '0; a_i = '0; b_i = '0; imm_i = '0;
        tick(); tick();
        rst_i = 1'b0;
        chk("rst_cmt", 64'(cmt_o), 64'd0);
        chk("rst_rid", 64'(rid_o), 64'd0);
        chk("rst_res", res_o, 64'd0);
        chk("rst_cause", 64'(cause_o), 64'd0);
        chk("rst_full", 64'(full_o), 64'd0);
        chk("rst_ovf", 64'(ovf_o), 64'd0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cmt_o) seen++;
        end
        chk("idle_no_cmt", 64'(seen), 64'd0);

        one_op("mulh",   6'd5, mk_ir(8'h02, 6'h0F), '1, '1, '0, 64'd0, 8'h00);
        one_op("mul",    6'd5, mk_ir(8'h02, 6'h06), '1, '1, '0, 64'd1, 8'h00);
        one_op("muluh",  6'd7, mk_ir(8'h02, 6'h1E), '1, 64'd2, '0, 64'd1, 8'h00);
        one_op("mulsuh", 6'd8, mk_ir(8'h02, 6'h1D), '1, 64'd2, '0, '1, 8'h00);
        one_op("muli",   6'd9, mk_ir(8'h06, 6'h00), 64'd7, 64'd100, -64'sd3,
               64'hFFFF_FFFF_FFFF_FFEB, 8'h00);
        one_op("mulu_big", 6'd10, mk_ir(8'h02, 6'h0E), 64'h1_0000_0001, 64'h1_0000_0003, '0,
               64'h0000_0004_0000_0003, 8'h00);

        // Fill the queue with results held off: rid 5 must be dropped
        ack_i = 1'b0;
        for (int r = 0; r < 6; r++) begin
            set_rec(6'(r), mk_ir(8'h02, 6'h06), 64'(r + 1), 64'd3, '0);
            if (r < 5) expect_res(6'(r), 64'(3 * (r + 1)), 8'h00);
            tick();
            if (r == 3) chk("full_pre", 64'(full_o), 64'd0);
            if (r == 4) begin
                chk("full_set", 64'(full_o), 64'd1);
                chk("ovf_pre", 64'(ovf_o), 64'd0);
            end
            if (r == 5) chk("ovf_pulse", 64'(ovf_o), 64'd1);
        end
        wr_i = 1'b0;
        tick();
        chk("ovf_clear", 64'(ovf_o), 64'd0);
        chk("full_hold", 64'(full_o), 64'd1);
        chk("cmt_held", 64'(cmt_o), 64'd1);
        chk("rid_held", 64'(rid_o), 64'd0);
        ack_i = 1'b1;
        tick();
        chk("full_drop", 64'(full_o), 64'd0);
        drain("full");

        // Flush during MUL2 of the first record: none of the three may commit
        set_rec(6'd20, mk_ir(8'h02, 6'h06), 64'd2, 64'd2, '0); tick();
        set_rec(6'd21, mk_ir(8'h02, 6'h06), 64'd3, 64'd3, '0); tick();
        set_rec(6'd22, mk_ir(8'h02, 6'h06), 64'd4, 64'd4, '0); tick();
        wr_i = 1'b0; flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush_full", 64'(full_o), 64'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (cmt_o) seen++;
        end
        chk("flush_no_cmt", 64'(seen), 64'd0);
        one_op("post_flush", 6'd23, mk_ir(8'h02, 6'h06), 64'd6, 64'd7, '0, 64'd42, 8'h00);

        // Unimplemented op followed back-to-back by a valid multiply
        expect_res(6'd30, 64'd0, 8'h37);
        expect_res(6'd31, 64'd15, 8'h00);
        set_rec(6'd30, mk_ir(8'h02, 6'h1C), 64'd5, 64'd3, '0); tick();
        set_rec(6'd31, mk_ir(8'h02, 6'h06), 64'd5, 64'd3, '0); tick();
        wr_i = 1'b0;
        drain("unimp");

        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cmt_o) seen++;
        end
        chk("final_idle", 64'(seen), 64'd0);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
